timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Sequencing controller that sits directly upstream of `counter` and drives its `clr_i`/`en_i`/`we_i`/`dat_i` inputs. It turns the counter into a programmable one-shot or periodic timer. The controller loads a start value, enables counting, and watches the counter's `dat_o` (fed back on `cnt_i`) for a compare match. On a match it raises an interrupt pulse, then either reloads or stops.

## Interface
- `WIDTH`, 8, counter data width; must equal the counter's `WIDTH`.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start pulse; latches `load_i`, `cmp_i` and `mode_i`.
- `stop_i`  in  1  abort; returns to IDLE and clears the counter.
- `mode_i`  in  1  0 = one-shot, 1 = periodic.
- `load_i`  in  WIDTH  start value.
- `cmp_i`  in  WIDTH  terminal value.
- `cnt_i`  in  WIDTH  counter `dat_o` feedback.
- `clr_o`  out  1  to counter `clr_i`.
- `en_o`  out  1  to counter `en_i`.
- `we_o`  out  1  to counter `we_i`.
- `dat_o`  out  WIDTH  to counter `dat_i`; always equals `load_q`.
- `irq_o`  out  1  one-cycle registered pulse per match.
- `busy_o`  out  1  high whenever state != IDLE.

## Operation
- Counter contract: synchronous, with priority `clr` > `we` > `en`. It increments by 1 modulo 2^WIDTH.
- Registers: `state`, `load_q`, `cmp_q`, `mode_q`, `irq_q`.
- States:
  - **IDLE**: all strobes low.
  - **LOAD**: `we_o` = 1.
  - **RUN**: counting.
  - **STOP**: `clr_o` = 1.
- Define `match = (cnt_i == cmp_q)`.
- IDLE transitions:
  - `start_i` & !`stop_i` → LOAD, and latch `load_i`, `cmp_i`, `mode_i`.
  - Otherwise stay.
- LOAD → RUN unconditionally.
- RUN outputs:
  - `en_o` = !`match`, so the counter never overshoots `cmp_q`.
  - `we_o` = `match` & `mode_q`.
- RUN transitions:
  - `match` & `mode_q`: reload in the same cycle and stay in RUN.
  - `match` & !`mode_q`: go to IDLE; the counter holds `cmp_q`.
  - `match` in either mode sets `irq_q` on the next edge.
- STOP → IDLE unconditionally.
- `stop_i` in LOAD or RUN → STOP. It overrides `start_i` and `match`, and a match in that cycle produces no irq. `stop_i` in IDLE or STOP has no effect.
- `start_i` in RUN restarts: re-latch the inputs and go to LOAD. A coincident match still raises irq, and `stop_i` wins over `start_i`. `start_i` in LOAD is ignored.
- Wrap-around: when `cmp_q` < `load_q`, the counter wraps through 2^WIDTH−1 → 0 before matching.
- `clr_o`, `en_o`, `we_o` and `dat_o` are combinational from `state`, `match` and the latched registers; at most one strobe is high per cycle.

## Timing
- Reset (async assert, sync release): state IDLE; `load_q`, `cmp_q`, `mode_q`, `irq_q` = 0. All outputs therefore read 0.
- `start_i` at edge N → LOAD in cycle N+1 (`we_o` high) → counter = L at N+2 (RUN).
- Periodic period: P = ((C − L) mod 2^WIDTH) + 1 cycles. This is P−1 increment cycles plus 1 reload cycle.
- `irq_o` rises one cycle after the match cycle and repeats every P cycles.
- One-shot: first `irq_o` at N+2+P.
  - `busy_o` falls in the same cycle `irq_o` rises.
- `cmp_q` == `load_q`, periodic: match every cycle, so `irq_o` stays high continuously and the counter holds L.
- `stop_i` at edge M → STOP in cycle M+1 (`clr_o` high) → counter = 0 and IDLE at M+2.
- Reset mid-RUN: all outputs drop to 0 immediately. The counter keeps its value unless it is reset too.

## Structure
- `timer_ctrl_pkg` holds:
  - the state encoding (IDLE, LOAD, RUN, STOP as 2-bit localparams);
  - the mode constants `MODE_ONESHOT` = 0 and `MODE_PERIODIC` = 1.
- No sub-module; a single always block for registers plus one combinational block for outputs.
- The bench instantiates `timer_ctrl` wired to `counter`.

## Test plan
All scenarios use WIDTH = 8.
- **Reset:** hold `rst_i` = 0 for 3 cycles with random inputs → all outputs 0, `busy_o` 0.
- **Periodic:** L = 0x10, C = 0x13, periodic start → `we_o` in cycle 1, counter 0x10..0x13, period 4. Check 3 consecutive `irq_o` pulses 4 cycles apart and a reload to 0x10 after each.
- **One-shot:** L = 0x00, C = 0x05 → exactly one `irq_o` at start+8. Counter holds 0x05, `busy_o` low, no further pulses over 20 cycles.
- **Wrap:** L = 0xFE, C = 0x01, one-shot → counter sequence FE, FF, 00, 01. `irq_o` after 4 RUN cycles.
- **Stop and priority:** `stop_i` mid-RUN at counter 0x12 → `clr_o` for one cycle, counter 0x00, IDLE. `stop_i` and `start_i` together in RUN → STOP, no reload.
- **Edge cases:** C == L periodic → `irq_o` high every cycle. `start_i` during RUN with new L = 0x40 → LOAD next cycle, counting resumes from 0x40.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: state encoding and mode constants for the timer sequencing controller.
package timer_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        RUN  = ST_RUN,
        STOP = ST_STOP
    } state_t;

endpackage

// File: rtl/counter.sv
// counter: loadable up-counter with priority clr > we > en, wrapping modulo 2^WIDTH.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o
);

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i)     dat_o <= '0;
        else if (clr_i) dat_o <= '0;
        else if (we_i)  dat_o <= dat_i;
        else if (en_i)  dat_o <= dat_o + 1'b1;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: drives a counter as a one-shot or periodic timer with compare-match interrupt.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] load_i,
    input  logic [WIDTH-1:0] cmp_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             clr_o,
    output logic             en_o,
    output logic             we_o,
    output logic [WIDTH-1:0] dat_o,
    output logic             irq_o,
    output logic             busy_o
);

    state_t           state;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] cmp_q;
    logic             mode_q;
    logic             irq_q;
    logic             match;
    logic             latch;

    assign match = cnt_i == cmp_q;
    // stop always wins; start is honoured only from IDLE or as a restart from RUN
    assign latch = start_i && !stop_i && (state == IDLE || state == RUN);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            load_q <= '0;
            cmp_q  <= '0;
            mode_q <= MODE_ONESHOT;
            irq_q  <= 1'b0;
        end else begin
            irq_q <= state == RUN && match && !stop_i;
            if (latch) begin
                load_q <= load_i;
                cmp_q  <= cmp_i;
                mode_q <= mode_i;
            end
            case (state)
                IDLE:    state <= latch ? LOAD : IDLE;
                LOAD:    state <= stop_i ? STOP : RUN;
                RUN:     state <= stop_i ? STOP : latch ? LOAD :
                                  (match && mode_q == MODE_ONESHOT) ? IDLE : RUN;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        clr_o  = state == STOP;
        en_o   = state == RUN && !match;
        we_o   = state == LOAD || (state == RUN && match && mode_q == MODE_PERIODIC);
        dat_o  = load_q;
        irq_o  = irq_q;
        busy_o = state != IDLE;
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: table-driven check of timer_ctrl driving a counter, plus reset sequences.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       crst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] load = '0;
    logic [7:0] cmp = '0;
    logic [7:0] cnt;
    logic [7:0] dat;
    logic       clr, en, we, irq, busy;

    int n_cmp = 0;
    int n_err = 0;

    // strobe patterns {clr, en, we, irq, busy}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_WE   = 5'b00101;
    localparam logic [4:0] O_EN   = 5'b01001;
    localparam logic [4:0] O_ENI  = 5'b01011;
    localparam logic [4:0] O_WEI  = 5'b00111;
    localparam logic [4:0] O_BUSY = 5'b00001;
    localparam logic [4:0] O_IRQ  = 5'b00010;
    localparam logic [4:0] O_CLR  = 5'b10001;

    typedef struct {
        logic        start;
        logic        stop;
        logic        mode;
        logic [7:0]  load;
        logic [7:0]  cmp;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    timer_ctrl #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stop_i(stop), .mode_i(mode),
        .load_i(load), .cmp_i(cmp), .cnt_i(cnt), .clr_o(clr), .en_o(en), .we_o(we),
        .dat_o(dat), .irq_o(irq), .busy_o(busy)
    );

    counter #(.WIDTH(8)) cnt_u (
        .clk_i(clk), .rst_i(crst_n), .clr_i(clr), .en_i(en), .we_i(we),
        .dat_i(dat), .dat_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push(input bit st, input bit sp, input bit md, input logic [7:0] ld,
                        input logic [7:0] cp, input logic [4:0] s, input logic [7:0] c);
        vec_t v;
        v.start = st; v.stop = sp; v.mode = md; v.load = ld; v.cmp = cp; v.exp = {s, c};
        tbl.push_back(v);
    endtask

    task automatic q(input logic [4:0] s, input logic [7:0] c);
        push(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, s, c);
    endtask

    initial begin
        // periodic L=10 C=13, three pulses, then stop at 0x12
        push(1, 0, 1, 8'h10, 8'h13, O_IDLE, 8'h00);
        q(O_WE, 8'h00);
        q(O_EN, 8'h10); q(O_EN, 8'h11); q(O_EN, 8'h12); q(O_WE, 8'h13);
        for (int i = 0; i < 2; i++) begin
            q(O_ENI, 8'h10); q(O_EN, 8'h11); q(O_EN, 8'h12); q(O_WE, 8'h13);
        end
        q(O_ENI, 8'h10); q(O_EN, 8'h11);
        push(0, 1, 0, 8'h00, 8'h00, O_EN, 8'h12);
        q(O_CLR, 8'h13); q(O_IDLE, 8'h00);
        // one-shot L=0 C=5, irq at start+8 then quiet
        push(1, 0, 0, 8'h00, 8'h05, O_IDLE, 8'h00);
        q(O_WE, 8'h00);
        for (int i = 0; i < 5; i++) q(O_EN, 8'(i));
        q(O_BUSY, 8'h05); q(O_IRQ, 8'h05);
        for (int i = 0; i < 20; i++) q(O_IDLE, 8'h05);
        // wrap FE..01 one-shot
        push(1, 0, 0, 8'hFE, 8'h01, O_IDLE, 8'h05);
        q(O_WE, 8'h05); q(O_EN, 8'hFE); q(O_EN, 8'hFF); q(O_EN, 8'h00);
        q(O_BUSY, 8'h01); q(O_IRQ, 8'h01); q(O_IDLE, 8'h01);
        // start+stop together in RUN: stop wins, no reload
        push(1, 0, 1, 8'h20, 8'h30, O_IDLE, 8'h01);
        q(O_WE, 8'h01); q(O_EN, 8'h20);
        push(1, 1, 1, 8'h40, 8'h45, O_EN, 8'h21);
        q(O_CLR, 8'h22); q(O_IDLE, 8'h00);
        // C == L periodic: irq every cycle; stop suppresses irq of a coincident match
        push(1, 0, 1, 8'h50, 8'h50, O_IDLE, 8'h00);
        q(O_WE, 8'h00); q(O_WE, 8'h50); q(O_WEI, 8'h50); q(O_WEI, 8'h50);
        push(0, 1, 0, 8'h00, 8'h00, O_WEI, 8'h50);
        q(O_CLR, 8'h50); q(O_IDLE, 8'h00);
        // restart during RUN with L=40
        push(1, 0, 1, 8'h60, 8'h70, O_IDLE, 8'h00);
        q(O_WE, 8'h00); q(O_EN, 8'h60);
        push(1, 0, 1, 8'h40, 8'h45, O_EN, 8'h61);
        q(O_WE, 8'h62); q(O_EN, 8'h40);
        push(0, 1, 0, 8'h00, 8'h00, O_EN, 8'h41);
        q(O_CLR, 8'h42); q(O_IDLE, 8'h00);
        // restart coincident with a periodic match still raises irq
        push(1, 0, 1, 8'h10, 8'h11, O_IDLE, 8'h00);
        q(O_WE, 8'h00); q(O_EN, 8'h10);
        push(1, 0, 1, 8'h30, 8'h31, O_WE, 8'h11);
        q(O_WEI, 8'h10); q(O_EN, 8'h30);
        push(0, 1, 0, 8'h00, 8'h00, O_WE, 8'h31);
        q(O_CLR, 8'h30); q(O_IDLE, 8'h00);
        // stop during LOAD
        push(1, 0, 0, 8'h77, 8'h78, O_IDLE, 8'h00);
        push(0, 1, 0, 8'h00, 8'h00, O_WE, 8'h00);
        q(O_CLR, 8'h77); q(O_IDLE, 8'h00);

        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); stop = 1'($urandom); mode = 1'($urandom);
            load = 8'($urandom); cmp = 8'($urandom);
            @(negedge clk);
            chk("reset_outputs", {clr, en, we, irq, busy, dat}, 13'h0);
        end
        start = 1'b0; stop = 1'b0; mode = 1'b0; load = '0; cmp = '0;
        rst_n = 1'b1; crst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            n_cmp++;
            if ({clr, en, we, irq, busy, cnt} !== tbl[i].exp) begin
                n_err++;
                $display("FAIL row%0d: got %b_%h expected %b_%h", i,
                         {clr, en, we, irq, busy}, cnt, tbl[i].exp[12:8], tbl[i].exp[7:0]);
            end
            start = tbl[i].start; stop = tbl[i].stop; mode = tbl[i].mode;
            load = tbl[i].load; cmp = tbl[i].cmp;
            @(negedge clk);
        end

        // reset mid-RUN: controller outputs drop at once, counter keeps its value
        start = 1'b1; mode = 1'b1; load = 8'h80; cmp = 8'h90;
        @(negedge clk);
        start = 1'b0;
        chk("load_dat", {we, dat}, {1'b1, 8'h80});
        @(negedge clk);
        @(negedge clk);
        chk("run_cnt", {en, cnt}, {1'b1, 8'h81});
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {clr, en, we, irq, busy, dat}, 13'h0);
        chk("async_reset_cnt_kept", cnt, 8'h81);
        @(negedge clk);
        chk("reset_cnt_held", {busy, cnt}, {1'b0, 8'h81});
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {clr, en, we, irq, busy, dat}, 13'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
